regfile_mp: RTL and testbench

- Parametrised multi-port register file, successor to the single-write/dual-read CPU register file.
- Provides configurable data width, address width and read-port count, plus two write ports with fixed priority.
- Clears its contents with a sequential hardware clear engine (after reset or on request), so storage can map to RAM.
- Sits in the decode/writeback stages of the pipelined core: reads in decode, writes from writeback.

---
 rtl/regfile_mp.sv | 144 ++++++++++++++
 tb/tb_regfile_mp.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
// Module   : regfile_mp
// Brief    : Parametrised register file with NREAD combinational read ports
//            and two prioritised write ports (port 1 wins on same address).
//            Contents are wiped by a one-entry-per-cycle clear sequencer that
//            runs after reset or on clear_req, so storage has no reset fan-out.
//            Optional macro REGFILE_MP_BYPASS_EN enables same-cycle
//            write-to-read forwarding.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_mp #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int NREAD    = 2,
   parameter int ZERO_REG = 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    clear_req,
   output logic                    busy,
   input  logic                    we0,
   input  logic [ADDR_W-1:0]       waddr0,
   input  logic [DATA_W-1:0]       wdata0,
   input  logic                    we1,
   input  logic [ADDR_W-1:0]       waddr1,
   input  logic [DATA_W-1:0]       wdata1,
   input  logic [NREAD*ADDR_W-1:0] raddr,
   output logic [NREAD*DATA_W-1:0] rdata
);

   localparam int              DEPTH    = 2**ADDR_W;
   localparam logic [ADDR_W:0] CLR_LAST = (ADDR_W+1)'(DEPTH-1);
   localparam logic [ADDR_W:0] CLR_ONE  = (ADDR_W+1)'(1);

   typedef enum logic [0:0] {
      ST_CLEAR = 1'b0,
      ST_IDLE  = 1'b1
   } state_t;

   state_t              state_q, state_d;
   logic [ADDR_W:0]     clr_cnt_q, clr_cnt_d;
   logic                busy_q, busy_d;
   logic                clr_we;
   logic                wr0_en, wr1_en;
   logic [DATA_W-1:0]   mem [DEPTH];

   // Clear sequencer next-state: walk clr_cnt across every entry, then idle
   always_comb begin
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      busy_d    = busy_q;
      clr_we    = 1'b0;
      case (state_q)
         ST_CLEAR: begin
            clr_we    = ~reset;
            clr_cnt_d = clr_cnt_q + CLR_ONE;
            if (clr_cnt_q == CLR_LAST) begin
               state_d = ST_IDLE;
               busy_d  = 1'b0;
            end else begin
               busy_d  = 1'b1;
            end
         end
         ST_IDLE: begin
            busy_d = 1'b0;
            if (clear_req) begin
               state_d   = ST_CLEAR;
               clr_cnt_d = '0;
               busy_d    = 1'b1;
            end
         end
         default: begin
            state_d   = ST_CLEAR;
            clr_cnt_d = '0;
            busy_d    = 1'b1;
         end
      endcase
   end

   // Sequencer state register; reset (re)starts the clear from entry 0
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_CLEAR;
         clr_cnt_q <= '0;
         busy_q    <= 1'b1;
      end else begin
         state_q   <= state_d;
         clr_cnt_q <= clr_cnt_d;
         busy_q    <= busy_d;
      end
   end

   // Write qualification: drop while clearing, on reset, to r0 when hardwired,
   // and drop port 0 when port 1 targets the same entry
   always_comb begin
      wr1_en = we1 & ~busy_q & ~reset & ~((ZERO_REG != 0) && (waddr1 == '0));
      wr0_en = we0 & ~busy_q & ~reset & ~((ZERO_REG != 0) && (waddr0 == '0))
               & ~(we1 && (waddr1 == waddr0));
   end

   // Storage: no reset, cleared only through the sequencer write port
   always_ff @(posedge clk) begin
      if (clr_we) begin
         mem[clr_cnt_q[ADDR_W-1:0]] <= '0;
      end
      if (wr0_en) begin
         mem[waddr0] <= wdata0;
      end
      if (wr1_en) begin
         mem[waddr1] <= wdata1;
      end
   end

   assign busy = busy_q;

   generate
      for (genvar k = 0; k < NREAD; k++) begin : g_rd
         logic [ADDR_W-1:0] ra;
         logic [DATA_W-1:0] rd;

         assign ra = raddr[k*ADDR_W +: ADDR_W];

         // Read lane mux: storage, optional forwarding, then busy/zero masking
         always_comb begin
            rd = mem[ra];
`ifdef REGFILE_MP_BYPASS_EN
            if (we1 && (waddr1 == ra)) begin
               rd = wdata1;
            end else if (we0 && (waddr0 == ra)) begin
               rd = wdata0;
            end
`endif
            if (busy_q || ((ZERO_REG != 0) && (ra == '0))) begin
               rd = '0;
            end
         end

         assign rdata[k*DATA_W +: DATA_W] = rd;
      end
   endgenerate

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_mp
// Brief    : Self-checking bench for regfile_mp. A ZERO_REG=1 two-lane
//            instance and a ZERO_REG=0 one-lane instance share all write and
//            control inputs and are compared against one array-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_mp;

   localparam int DEPTH = 32;

   logic        clk = 1'b0;
   logic        reset, clear_req;
   logic        we0, we1;
   logic [4:0]  waddr0, waddr1;
   logic [31:0] wdata0, wdata1;
   logic [4:0]  ra0, ra1, ra_nz;
   logic [9:0]  raddr;
   logic [63:0] rdata;
   logic        busy;
   logic [31:0] rdata_nz;
   logic        busy_nz;

   int n_cmp = 0;
   int n_err = 0;
   int n;

   logic [31:0] m_mem [DEPTH];
   bit          m_busy  = 1'b1;
   int          m_left  = 0;
   bit          m_valid = 1'b0;

   typedef struct {
      bit          we0;
      logic [4:0]  wa0;
      logic [31:0] wd0;
      bit          we1;
      logic [4:0]  wa1;
      logic [31:0] wd1;
      logic [4:0]  ra0;
      logic [4:0]  ra1;
      logic [31:0] e0;
      logic [31:0] e1;
   } vec_t;

   vec_t vt [6];

   assign raddr = {ra1, ra0};

   always #5 clk = ~clk;

   regfile_mp #(.DATA_W(32), .ADDR_W(5), .NREAD(2), .ZERO_REG(1)) u_dut (
      .clk(clk), .reset(reset), .clear_req(clear_req), .busy(busy),
      .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
      .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
      .raddr(raddr), .rdata(rdata)
   );

   regfile_mp #(.DATA_W(32), .ADDR_W(5), .NREAD(1), .ZERO_REG(0)) u_dut_nz (
      .clk(clk), .reset(reset), .clear_req(clear_req), .busy(busy_nz),
      .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
      .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
      .raddr(ra_nz), .rdata(rdata_nz)
   );

   // Expected read value from the architectural rules
   function automatic logic [31:0] exp_rd(logic [4:0] a, bit zero_reg);
      if (m_busy) return 32'h0;
      if (zero_reg && a == 5'd0) return 32'h0;
`ifdef REGFILE_MP_BYPASS_EN
      if (we1 && waddr1 == a) return wdata1;
      if (we0 && waddr0 == a) return wdata0;
`endif
      return m_mem[a];
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Model update for one rising edge
   task automatic model_edge();
      if (reset) begin
         m_valid = 1'b1;
         m_busy  = 1'b1;
         m_left  = DEPTH;
      end else if (m_valid) begin
         if (m_busy) begin
            m_left--;
            if (m_left == 0) begin
               m_busy = 1'b0;
               for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'h0;
            end
         end else begin
            if (we0) m_mem[waddr0] = wdata0;
            if (we1) m_mem[waddr1] = wdata1;
            if (clear_req) begin
               m_busy = 1'b1;
               m_left = DEPTH;
            end
         end
      end
   endtask

   // Check outputs mid-cycle, take one edge, return at the next falling edge
   task automatic step();
      #1;
      if (m_valid) begin
         check("busy", {31'b0, busy}, {31'b0, m_busy});
         check("busy_nz", {31'b0, busy_nz}, {31'b0, m_busy});
         check("lane0", rdata[31:0], exp_rd(ra0, 1'b1));
         check("lane1", rdata[63:32], exp_rd(ra1, 1'b1));
         check("nz_lane", rdata_nz, exp_rd(ra_nz, 1'b0));
      end
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic quiet();
      reset = 1'b0; clear_req = 1'b0; we0 = 1'b0; we1 = 1'b0;
   endtask

   initial begin
      vt[0] = '{1'b1, 5'd5,  32'h12345678, 1'b0, 5'd0, 32'h0,
                5'd5, 5'd0, 32'h12345678, 32'h0};
      vt[1] = '{1'b1, 5'd7,  32'h11111111, 1'b1, 5'd7, 32'h22222222,
                5'd7, 5'd7, 32'h22222222, 32'h22222222};
      vt[2] = '{1'b1, 5'd8,  32'hAAAA0008, 1'b1, 5'd9, 32'hBBBB0009,
                5'd8, 5'd9, 32'hAAAA0008, 32'hBBBB0009};
      vt[3] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0, 32'hFFFFFFFF,
                5'd0, 5'd5, 32'h0, 32'h12345678};
      vt[4] = '{1'b1, 5'd31, 32'hCAFEF00D, 1'b1, 5'd1, 32'h00000001,
                5'd31, 5'd1, 32'hCAFEF00D, 32'h00000001};
      vt[5] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,
                5'd3, 5'd7, 32'h0, 32'h22222222};

      reset = 1'b1; clear_req = 1'b0; we0 = 1'b0; we1 = 1'b0;
      waddr0 = '0; waddr1 = '0; wdata0 = '0; wdata1 = '0;
      ra0 = 5'd3; ra1 = 5'd0; ra_nz = 5'd3;
      @(negedge clk);
      step();
      step();
      check("busy_after_reset", {31'b0, busy}, 32'd1);

      // Release reset; a write during the clear must be lost
      reset = 1'b0; we0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'hDEADBEEF;
      n = 0;
      step();
      n++;
      we0 = 1'b0;
      while (busy === 1'b1 && n < 40) begin
         step();
         n++;
      end
      check("clear_len", 32'(n), 32'd32);
      #1;
      check("r3_after_clear", rdata[31:0], 32'h0);
      check("nz_r3_after_clear", rdata_nz, 32'h0);

      // Table vectors: write cycle, then read-back cycle
      for (int i = 0; i < 6; i++) begin
         quiet();
         we0 = vt[i].we0; waddr0 = vt[i].wa0; wdata0 = vt[i].wd0;
         we1 = vt[i].we1; waddr1 = vt[i].wa1; wdata1 = vt[i].wd1;
         ra0 = vt[i].ra0; ra1 = vt[i].ra1; ra_nz = vt[i].ra0;
         step();
         we0 = 1'b0; we1 = 1'b0;
         #1;
         check($sformatf("vec%0d_lane0", i), rdata[31:0], vt[i].e0);
         check($sformatf("vec%0d_lane1", i), rdata[63:32], vt[i].e1);
         step();
      end
      ra_nz = 5'd0;
      #1;
      check("nz_r0_written", rdata_nz, 32'hFFFFFFFF);
      step();

      // Same-cycle read of a write: forwarded or old value
      we0 = 1'b1; waddr0 = 5'd4; wdata0 = 32'h44444444;
      step();
      we0 = 1'b0;
      we1 = 1'b1; waddr1 = 5'd4; wdata1 = 32'hA5A5A5A5; ra0 = 5'd4;
      #1;
`ifdef REGFILE_MP_BYPASS_EN
      check("bypass_same_cycle", rdata[31:0], 32'hA5A5A5A5);
`else
      check("bypass_same_cycle", rdata[31:0], 32'h44444444);
`endif
      step();
      we1 = 1'b0;
      #1;
      check("bypass_next_cycle", rdata[31:0], 32'hA5A5A5A5);
      step();

      // clear_req with populated registers; second request mid-clear ignored
      clear_req = 1'b1;
      step();
      clear_req = 1'b0;
      n = 0;
      while (busy === 1'b1 && n < 40) begin
         step();
         n++;
         clear_req = (n == 10);
      end
      clear_req = 1'b0;
      check("clear_req_len", 32'(n), 32'd32);
      for (int a = 0; a < DEPTH; a++) begin
         ra0 = 5'(a); ra1 = 5'(31 - a); ra_nz = 5'(a);
         #1;
         check($sformatf("cleared_r%0d", a), rdata[31:0], 32'h0);
         check($sformatf("nz_cleared_r%0d", a), rdata_nz, 32'h0);
         step();
      end

      // Reset part-way through a clear restarts the full sequence
      we0 = 1'b1; waddr0 = 5'd12; wdata0 = 32'h0BADF00D;
      step();
      we0 = 1'b0;
      clear_req = 1'b1;
      step();
      clear_req = 1'b0;
      for (int i = 0; i < 15; i++) step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      n = 0;
      while (busy === 1'b1 && n < 40) begin
         step();
         n++;
      end
      check("restart_len", 32'(n), 32'd32);

      // Randomised traffic against the model
      for (int i = 0; i < 600; i++) begin
         reset     = ($urandom_range(0, 249) == 0);
         clear_req = ($urandom_range(0, 59) == 0);
         we0    = 1'($urandom_range(0, 1));
         we1    = 1'($urandom_range(0, 1));
         waddr0 = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
         waddr1 = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
         wdata0 = $urandom;
         wdata1 = $urandom;
         ra0    = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
         ra1    = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
         ra_nz  = 5'($urandom_range(0, 7));
         step();
      end
      quiet();
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
